mrelbp_ci_frame_ctrl: RTL and testbench
=======================================

# mrelbp_ci_frame_ctrl

Frame-level sequencer for the MRELBP centre-intensity (CI) sliding-window sum datapath. It counts raster-order pixels of a COLS x ROWS frame and issues the load, accumulate and slide enables that build a KxK window sum from per-column sums. It also flags valid windows and reports frame completion. It sits between the pixel source and the per-radius CI sum/compare datapath, replacing per-radius ad-hoc counters.

## Interface
- COLS, 11, frame width in pixels (>= K)
- ROWS, 11, frame height in pixels (>= K)
- K, 9, window side (9 for R4; odd, >= 3)
- LAT, 2, datapath cycles from window-complete enable to CI bit valid (>= 1)

- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start_i  in  1  frame start pulse; pixel counters clear
- valid_i  in  1  one pixel present this cycle (raster order, gaps allowed)
- ld_en_o  out  1  accumulator <= incoming column sum
- acc_en_o  out  1  accumulator += incoming column sum
- slide_en_o  out  1  accumulator += incoming column − column K back
- win_valid_o  out  1  accumulator holds a full KxK sum after this cycle's update
- ci_valid_o  out  1  datapath CI output valid (win_valid_o delayed LAT)
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse with the last ci_valid_o of the frame
- progress_done_o  out  1  level: frame finished, held until next start_i
- err_o  out  1  sticky protocol error (only with MRELBP_CI_CTRL_ERR_EN)

## Operation
- States: IDLE, FILL, RUN, FLUSH.
- IDLE:
  - valid_i is ignored.
  - start_i -> FILL, with row = col = 0.
  - If valid_i is high in the same cycle as start_i, that pixel is pixel (0,0), and counters advance to col = 1.
- Each accepted pixel increments col. At col == COLS−1, col wraps to 0 and row increments.
- FILL (row < K−1): the line buffers fill. No ld/acc/slide/win enables are issued. Leaving row K−2 -> RUN.
- RUN: for each accepted pixel at column c:
  - c == 0: ld_en_o.
  - 1 <= c <= K−1: acc_en_o.
  - c >= K: slide_en_o.
  - c >= K−1: win_valid_o also asserts.
  - Exactly one of ld/acc/slide fires per accepted pixel.
- Pixel (ROWS−1, COLS−1) accepted -> FLUSH. A down-counter is loaded with LAT.
- FLUSH:
  - valid_i is ignored.
  - When the counter expires (the final ci_valid_o cycle), done_o pulses, progress_done_o sets, and the state returns to IDLE.
- Windows per frame: (COLS−K+1)*(ROWS−K+1). This equals the number of ci_valid_o pulses; 9 for defaults.
- start_i in FILL, RUN or FLUSH: abort and restart at FILL with row = col = 0. The LAT delay line is cleared. No done_o is issued for the aborted frame.
- start_i always clears progress_done_o.
- Counter widths: $clog2(COLS), $clog2(ROWS), $clog2(LAT+1).

## Timing
- Enables are registered: a pixel sampled with valid_i at edge t produces its enables during cycle t+1. This aligns them with the datapath's registered column sums.
- ci_valid_o(t) = win_valid_o(t−LAT), implemented as a LAT-deep shift register.
- done_o coincides with the last ci_valid_o.
- Gaps in valid_i produce gaps in the enables; no enable is issued without an accepted pixel.
- Reset values: state IDLE, counters 0, all outputs 0 (including progress_done_o and err_o).
- rst mid-frame: everything returns to reset values on the next edge. The delay line is flushed.

## Configuration
- MRELBP_CI_CTRL_ERR_EN defined:
  - err_o sets (sticky until rst) on start_i in FILL, RUN or FLUSH.
  - err_o also sets on valid_i in FLUSH, or on valid_i in IDLE when progress_done_o = 1 (overrun).
  - Abort behaviour is unchanged.
- Undefined: err_o is tied to 0 and no error logic is built.

## Structure
- Shared package mrelbp_pkg holds:
  - the state typedef (IDLE/FILL/RUN/FLUSH);
  - per-radius window constants (K_R2 = 5, K_R4 = 9, K_R6 = 13, K_R8 = 17);
  - the default LAT.
- One natural sub-module: mrelbp_valid_delay, a parameterised LAT-stage valid shift register with synchronous clear. It is reused by other radii.

## Test plan
- Defaults, 121 contiguous pixels after start_i:
  - no enables during the first 88 pixels;
  - 9 win_valid_o, 9 ci_valid_o;
  - done_o on ci_valid_o #9, exactly 2 cycles after the last win_valid_o;
  - progress_done_o high afterwards.
- Row 8 enable pattern: ld at c0, acc at c1..c8, slide at c9..c10; win_valid at c8..c10.
- Random valid_i gaps (50%): the enable sequence matches the contiguous run pixel-for-pixel; counts unchanged.
- start_i at pixel 95 of frame 1, then a full frame:
  - no done_o for the aborted frame;
  - the second frame gives 9 ci_valid_o;
  - with MRELBP_CI_CTRL_ERR_EN, err_o = 1.
- start_i together with valid_i: that pixel is counted as (0,0); done_o after pixel 121.
- rst asserted in RUN: next cycle all outputs 0 and busy_o = 0; a following frame completes normally.

Source files
------------

// File: rtl/mrelbp_pkg.sv
// Shared MRELBP definitions: CI sequencer state encoding, per-radius window
// sides and the default CI datapath latency.
package mrelbp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } ci_state_e;

   localparam int K_R2 = 5;
   localparam int K_R4 = 9;
   localparam int K_R6 = 13;
   localparam int K_R8 = 17;

   localparam int CI_LAT_DEFAULT = 2;

endpackage

// File: rtl/mrelbp_valid_delay.sv
// LAT-stage valid shift register with synchronous clear, shared by all
// per-radius CI sequencers to align window-valid with the datapath output.
module mrelbp_valid_delay
   import mrelbp_pkg::*;
#(
   parameter int LAT = CI_LAT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic vld_i,
   output logic vld_o
);

   logic [LAT-1:0] sr_q;

   generate
      if (LAT == 1) begin : g_one
         always_ff @(posedge clk) begin
            if (rst || clr_i) sr_q <= '0;
            else              sr_q <= vld_i;
         end
      end else begin : g_multi
         always_ff @(posedge clk) begin
            if (rst || clr_i) sr_q <= '0;
            else              sr_q <= {sr_q[LAT-2:0], vld_i};
         end
      end
   endgenerate

   assign vld_o = sr_q[LAT-1];

endmodule

// File: rtl/mrelbp_ci_frame_ctrl.sv
// Frame sequencer for the MRELBP CI sliding-window sum: raster pixel counting,
// registered ld/acc/slide enables, window/CI valid and frame completion.
// Optional protocol error flag built only with MRELBP_CI_CTRL_ERR_EN defined.
module mrelbp_ci_frame_ctrl
   import mrelbp_pkg::*;
#(
   parameter int COLS = 11,
   parameter int ROWS = 11,
   parameter int K    = K_R4,
   parameter int LAT  = CI_LAT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic valid_i,
   output logic ld_en_o,
   output logic acc_en_o,
   output logic slide_en_o,
   output logic win_valid_o,
   output logic ci_valid_o,
   output logic busy_o,
   output logic done_o,
   output logic progress_done_o,
   output logic err_o
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int LW = $clog2(LAT + 1);

   localparam logic [CW-1:0] COL_LAST      = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(ROWS - 1);
   localparam logic [RW-1:0] ROW_FILL_LAST = RW'(K - 2);
   // One extra bit so K == COLS (e.g. power-of-two widths) cannot alias to 0.
   localparam logic [CW:0]   K_C           = (CW + 1)'(K);
   localparam logic [CW:0]   KM1_C         = (CW + 1)'(K - 1);
   localparam logic [LW-1:0] LAT_C         = LW'(LAT);

   ci_state_e     state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          prog_q, prog_d;
   logic          ld_q, acc_q, slide_q, win_q;
   logic          ld_d, acc_d, slide_d, win_d;
   logic          run_px;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      prog_d  = prog_q;
      run_px  = 1'b0;
      if (start_i) begin
         // Start (or abort) restarts the frame; a coincident pixel is (0,0).
         state_d = ST_FILL;
         row_d   = '0;
         col_d   = valid_i ? CW'(1) : '0;
         cnt_d   = '0;
         prog_d  = 1'b0;
      end else begin
         case (state_q)
            ST_FILL, ST_RUN: begin
               if (valid_i) begin
                  run_px = (state_q == ST_RUN);
                  if (col_q == COL_LAST) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                     if (state_q == ST_FILL && row_q == ROW_FILL_LAST) begin
                        state_d = ST_RUN;
                     end
                     if (state_q == ST_RUN && row_q == ROW_LAST) begin
                        state_d = ST_FLUSH;
                        row_d   = '0;
                        cnt_d   = LAT_C;
                     end
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
            ST_FLUSH: begin
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
                  prog_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ld_d    = run_px && (col_q == '0);
      acc_d   = run_px && (col_q != '0) && ({1'b0, col_q} <= KM1_C);
      slide_d = run_px && ({1'b0, col_q} >= K_C);
      win_d   = run_px && ({1'b0, col_q} >= KM1_C);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         cnt_q   <= '0;
         prog_q  <= 1'b0;
         ld_q    <= 1'b0;
         acc_q   <= 1'b0;
         slide_q <= 1'b0;
         win_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         prog_q  <= prog_d;
         ld_q    <= ld_d;
         acc_q   <= acc_d;
         slide_q <= slide_d;
         win_q   <= win_d;
      end
   end

   // Any start flushes in-flight window valids so an aborted frame emits no CI.
   mrelbp_valid_delay #(.LAT(LAT)) u_ci_dly (
      .clk   (clk),
      .rst   (rst),
      .clr_i (start_i),
      .vld_i (win_q),
      .vld_o (ci_valid_o)
   );

`ifdef MRELBP_CI_CTRL_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q
            | (start_i && state_q != ST_IDLE)
            | (valid_i && state_q == ST_FLUSH)
            | (valid_i && !start_i && state_q == ST_IDLE && prog_q);
   end

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign ld_en_o         = ld_q;
   assign acc_en_o        = acc_q;
   assign slide_en_o      = slide_q;
   assign win_valid_o     = win_q;
   assign busy_o          = (state_q != ST_IDLE);
   assign done_o          = (state_q == ST_FLUSH) && (cnt_q == '0);
   assign progress_done_o = prog_q;

endmodule

// File: tb/tb_mrelbp_ci_frame_ctrl.sv
// Self-checking bench for mrelbp_ci_frame_ctrl (default 11x11 frame, K=9, LAT=2).
module tb_mrelbp_ci_frame_ctrl;

   localparam int COLS = 11;
   localparam int ROWS = 11;
   localparam int K    = 9;
   localparam int LAT  = 2;
   localparam int NPIX = COLS * ROWS;
   localparam int NWIN = (COLS - K + 1) * (ROWS - K + 1);
   localparam int NTAB = NPIX + 1 + LAT + 3;

   logic clk = 1'b0;
   logic rst, start_i, valid_i;
   logic ld_en_o, acc_en_o, slide_en_o, win_valid_o, ci_valid_o;
   logic busy_o, done_o, progress_done_o, err_o;

   always #5 clk = ~clk;

   mrelbp_ci_frame_ctrl #(.COLS(COLS), .ROWS(ROWS), .K(K), .LAT(LAT)) dut (
      .clk             (clk),
      .rst             (rst),
      .start_i         (start_i),
      .valid_i         (valid_i),
      .ld_en_o         (ld_en_o),
      .acc_en_o        (acc_en_o),
      .slide_en_o      (slide_en_o),
      .win_valid_o     (win_valid_o),
      .ci_valid_o      (ci_valid_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .progress_done_o (progress_done_o),
      .err_o           (err_o)
   );

   typedef struct {
      bit       s;
      bit       v;
      bit [3:0] en;   // {ld, acc, slide, win} expected after this cycle's edge
   } vec_t;

   typedef struct {
      int       col;
      bit [3:0] en;
   } row_vec_t;

   vec_t     frame_tab[NTAB];
   row_vec_t row8_tab[COLS];

   int errors = 0;
   int checks = 0;

   // reference model state (pixel-index based)
   int       mode;      // 0 idle, 1 accepting pixels, 2 flushing
   int       pix, fl, last_acc;
   bit       m_prog, m_err;
   bit [3:0] m_en;
   bit       h[0:LAT];

   // statistics
   int       cyc, win_cnt, ci_cnt, done_cnt, early_en, last_win_cyc, done_cyc, ci_at_done;
   bit [3:0] cur_seq[NPIX];
   bit [3:0] ref_seq[NPIX];

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic bit [3:0] exp_en(input int p);
      int r, c;
      r = p / COLS;
      c = p % COLS;
      if (r < K - 1) return 4'b0000;
      return {c == 0, (c >= 1) && (c <= K - 1), c >= K, c >= K - 1};
   endfunction

   task automatic model_reset();
      mode = 0; pix = 0; fl = 0; last_acc = -1;
      m_prog = 0; m_err = 0; m_en = 4'b0000;
      for (int i = 0; i <= LAT; i++) h[i] = 1'b0;
   endtask

   task automatic model_step(input bit s, input bit v);
      last_acc = -1;
`ifdef MRELBP_CI_CTRL_ERR_EN
      if (s && mode != 0) m_err = 1'b1;
      if (v && !s && mode == 2) m_err = 1'b1;
      if (v && !s && mode == 0 && m_prog) m_err = 1'b1;
`endif
      if (s) begin
         mode = 1; pix = 0; m_prog = 1'b0;
         if (v) begin last_acc = 0; pix = 1; end
      end else if (mode == 1) begin
         if (v) begin
            last_acc = pix;
            pix++;
            if (last_acc == NPIX - 1) begin mode = 2; fl = 0; end
         end
      end else if (mode == 2) begin
         if (fl == LAT) begin mode = 0; m_prog = 1'b1; end
         else fl++;
      end
      m_en = (last_acc >= 0) ? exp_en(last_acc) : 4'b0000;
      if (s) begin
         for (int i = 1; i <= LAT; i++) h[i] = 1'b0;
      end else begin
         for (int i = LAT; i >= 1; i--) h[i] = h[i-1];
      end
      h[0] = m_en[0];
   endtask

   task automatic clear_stats();
      win_cnt = 0; ci_cnt = 0; done_cnt = 0; early_en = 0;
      last_win_cyc = -100; done_cyc = -1; ci_at_done = -1;
      for (int i = 0; i < NPIX; i++) cur_seq[i] = 4'b0000;
   endtask

   task automatic run_cycle(input bit s, input bit v);
      bit [8:0] got, exp;
      start_i = s;
      valid_i = v;
      @(posedge clk);
      #1;
      cyc++;
      model_step(s, v);
      got = {ld_en_o, acc_en_o, slide_en_o, win_valid_o, ci_valid_o,
             busy_o, done_o, progress_done_o, err_o};
      exp = {m_en, h[LAT], mode != 0, (mode == 2) && (fl == LAT), m_prog, m_err};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL outputs cyc=%0d {ld,acc,slide,win,ci,busy,done,prog,err}: got %b expected %b",
                  cyc, got, exp);
      end
      if (win_valid_o) begin win_cnt++; last_win_cyc = cyc; end
      if (ci_valid_o) ci_cnt++;
      if (done_o) begin done_cnt++; done_cyc = cyc; ci_at_done = ci_cnt; end
      if (last_acc >= 0) begin
         cur_seq[last_acc] = {ld_en_o, acc_en_o, slide_en_o, win_valid_o};
         if (last_acc < (K - 1) * COLS && cur_seq[last_acc] != 4'b0000) early_en++;
      end
   endtask

   task automatic do_reset(input bit v);
      rst = 1'b1; start_i = 1'b0; valid_i = v;
      @(posedge clk);
      #1;
      cyc++;
      model_reset();
      check("reset outputs", int'({ld_en_o, acc_en_o, slide_en_o, win_valid_o, ci_valid_o,
                                  busy_o, done_o, progress_done_o, err_o}), 0);
      check("reset busy", int'(busy_o), 0);
      rst = 1'b0; valid_i = 1'b0;
   endtask

   task automatic flush_cycles();
      repeat (LAT + 3) run_cycle(1'b0, 1'b0);
   endtask

   task automatic frame_summary(input string tag);
      check({tag, " ci count"}, ci_cnt, NWIN);
      check({tag, " done count"}, done_cnt, 1);
      check({tag, " ci count at done"}, ci_at_done, NWIN);
      check({tag, " progress_done"}, int'(progress_done_o), 1);
      check({tag, " busy idle"}, int'(busy_o), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int mism;
      int n;

      // contiguous frame: start alone, then 121 pixels, then flush cycles
      for (int i = 0; i < NTAB; i++) begin
         frame_tab[i].s  = (i == 0);
         frame_tab[i].v  = (i >= 1) && (i <= NPIX);
         frame_tab[i].en = (i >= 1 && i <= NPIX) ? exp_en(i - 1) : 4'b0000;
      end
      row8_tab = '{'{0, 4'b1000}, '{1, 4'b0100}, '{2, 4'b0100}, '{3, 4'b0100},
                   '{4, 4'b0100}, '{5, 4'b0100}, '{6, 4'b0100}, '{7, 4'b0100},
                   '{8, 4'b0101}, '{9, 4'b0011}, '{10, 4'b0011}};

      cyc = 0;
      rst = 1'b1; start_i = 1'b0; valid_i = 1'b0;
      model_reset();
      do_reset(1'b0);
      do_reset(1'b0);
      run_cycle(1'b0, 1'b1);   // valid in IDLE is ignored

      // ---- contiguous frame ----
      clear_stats();
      for (int i = 0; i < NTAB; i++) begin
         run_cycle(frame_tab[i].s, frame_tab[i].v);
         check("table enables", int'({ld_en_o, acc_en_o, slide_en_o, win_valid_o}),
               int'(frame_tab[i].en));
         if (last_acc >= 8 * COLS && last_acc < 9 * COLS) begin
            check($sformatf("row8 c%0d", row8_tab[last_acc - 8 * COLS].col),
                  int'({ld_en_o, acc_en_o, slide_en_o, win_valid_o}),
                  int'(row8_tab[last_acc - 8 * COLS].en));
         end
      end
      check("A early enables", early_en, 0);
      check("A win count", win_cnt, NWIN);
      check("A done after last win", done_cyc - last_win_cyc, LAT);
      frame_summary("A");
      for (int i = 0; i < NPIX; i++) ref_seq[i] = exp_en(i);

      // ---- random 50% gaps ----
      clear_stats();
      run_cycle(1'b1, 1'b0);
      n = 0;
      while (mode == 1 && n < 2000) begin
         run_cycle(1'b0, 1'($urandom_range(0, 1)));
         n++;
      end
      check("gap pixels accepted in budget", pix, NPIX);
      flush_cycles();
      mism = 0;
      for (int i = 0; i < NPIX; i++) if (cur_seq[i] != ref_seq[i]) mism++;
      check("gap enable sequence mismatches", mism, 0);
      check("gap win count", win_cnt, NWIN);
      frame_summary("gap");

      // ---- abort at pixel 95, then full frame ----
      clear_stats();
      run_cycle(1'b1, 1'b0);
      repeat (95) run_cycle(1'b0, 1'b1);
      check("abort no done yet", done_cnt, 0);
      run_cycle(1'b1, 1'b0);
      check("abort busy", int'(busy_o), 1);
      repeat (NPIX) run_cycle(1'b0, 1'b1);
      flush_cycles();
      frame_summary("abort");
`ifdef MRELBP_CI_CTRL_ERR_EN
      check("abort err_o", int'(err_o), 1);
`else
      check("abort err_o", int'(err_o), 0);
`endif

      // ---- start together with valid ----
      clear_stats();
      run_cycle(1'b1, 1'b1);
      check("start+valid prog cleared", int'(progress_done_o), 0);
      repeat (NPIX - 1) run_cycle(1'b0, 1'b1);
      check("start+valid last pixel index", last_acc, NPIX - 1);
      flush_cycles();
      check("start+valid done after last win", done_cyc - last_win_cyc, LAT);
      frame_summary("start+valid");

      // ---- rst in RUN, then a normal frame ----
      clear_stats();
      run_cycle(1'b1, 1'b0);
      repeat (100) run_cycle(1'b0, 1'b1);
      check("pre-reset busy", int'(busy_o), 1);
      do_reset(1'b1);
      run_cycle(1'b0, 1'b1);   // ignored in IDLE after reset
      clear_stats();
      run_cycle(1'b1, 1'b0);
      repeat (NPIX) run_cycle(1'b0, 1'b1);
      flush_cycles();
      frame_summary("post-reset");
      check("post-reset err_o", int'(err_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
